// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/DM memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } mem_owner_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam int          STREAK_W = 4;

endpackage

// File: rtl/mem_arb_fairness.sv
// Priority decision for the shared RAM port: DM wins unless it has starved IF
// for MAX_DM_STREAK consecutive grants, in which case IF gets one cycle.
module mem_arb_fairness
  import mem_arb_pkg::*;
#(
  parameter int MAX_DM_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dm_req,
  output logic if_win,
  output logic dm_win
);

  logic [STREAK_W-1:0] r_streak;
  logic                w_if_turn;

  assign w_if_turn = if_req && (r_streak == STREAK_W'(MAX_DM_STREAK));

  // Grants are forced low while reset is held, independent of requests.
  assign dm_win = rst && dm_req && !w_if_turn;
  assign if_win = rst && if_req && !dm_win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_streak <= '0;
    end else if (dm_win && if_req) begin
      if (r_streak != '1) begin
        r_streak <= r_streak + STREAK_W'(1);
      end
    end else if (if_win || !if_req) begin
      r_streak <= '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, 1-cycle-latency RAM between instruction fetch and
// the data-memory stage; responses are steered back by the registered owner.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                dm_req,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic                dm_wr_en,
  input  logic [DATA_W-1:0]   dm_wr_data,
  input  logic [DATA_W/8-1:0] dm_byte_en,
  output logic                dm_gnt,
  output logic                dm_rsp_valid,
  output logic [DATA_W-1:0]   dm_rsp_data,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wr_en,
  output logic [DATA_W-1:0]   mem_wr_data,
  output logic [DATA_W/8-1:0] mem_byte_en,
  input  logic [DATA_W-1:0]   mem_rd_data
);

  logic              w_if_win;
  logic              w_dm_win;
  logic [ADDR_W-1:0] r_last_addr;
  mem_owner_t        r_owner;
  logic              r_was_store;

  mem_arb_fairness #(
    .MAX_DM_STREAK (MAX_DM_STREAK)
  ) u_fairness (
    .clk    (clk),
    .rst    (rst),
    .if_req (if_req),
    .dm_req (dm_req),
    .if_win (w_if_win),
    .dm_win (w_dm_win)
  );

  assign if_gnt = w_if_win;
  assign dm_gnt = w_dm_win;

  // Idle cycles park the address on the last granted value to avoid RAM toggling.
  always_comb begin
    mem_addr    = r_last_addr;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    mem_byte_en = '0;
    if (w_dm_win) begin
      mem_addr    = dm_addr;
      mem_wr_en   = dm_wr_en;
      mem_wr_data = dm_wr_data;
      mem_byte_en = dm_byte_en;
    end else if (w_if_win) begin
      mem_addr    = if_addr;
      mem_byte_en = '1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_addr <= '0;
      r_owner     <= OWN_NONE;
      r_was_store <= 1'b0;
    end else if (w_dm_win) begin
      r_last_addr <= dm_addr;
      r_owner     <= OWN_DM;
      r_was_store <= dm_wr_en;
    end else if (w_if_win) begin
      r_last_addr <= if_addr;
      r_owner     <= OWN_IF;
      r_was_store <= 1'b0;
    end else begin
      r_owner     <= OWN_NONE;
      r_was_store <= 1'b0;
    end
  end

  assign if_rsp_valid = (r_owner == OWN_IF);
  assign dm_rsp_valid = (r_owner == OWN_DM);
  assign if_rsp_data  = if_rsp_valid ? mem_rd_data : '0;
  assign dm_rsp_data  = (dm_rsp_valid && !r_was_store) ? mem_rd_data : '0;

endmodule
